// File: rtl/step_clock_ctrl.sv
// step_clock_ctrl: debounced manual single-step and fixed-rate auto-run step enables for the core.
module step_clock_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RUN_DIV         = 50000000,
  parameter int COUNT_W         = 16
) (
  input  logic               clock_reg,
  input  logic               reset,
  input  logic               key_n,
  input  logic               run_sw,
  input  logic               halt,
  output logic               step_en,
  output logic               key_level,
  output logic               running,
  output logic [COUNT_W-1:0] step_count
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DW = $clog2(RUN_DIV);
  typedef enum logic [2:0] {LOCK, IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;
  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [DW-1:0]      r_div;
  logic [COUNT_W-1:0] r_count;
  logic               r_key_meta, r_key_sync, r_run_meta, r_run_sync;
  logic               r_running, r_step_en;
  logic               w_key_s, w_last, w_press, w_manual, w_div_en, w_auto, w_step;
  assign w_key_s  = ~r_key_sync;
  assign w_last   = (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press     = 1'b0;
    case (r_state)
      LOCK: begin
        if (w_key_s) w_cnt_nxt = '0;
        else if (w_last) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else w_cnt_nxt = r_cnt + 1'b1;
      end
      IDLE: begin
        if (w_key_s) begin
          w_state_nxt = PRESS_CHK;
          w_cnt_nxt   = '0;
        end
      end
      PRESS_CHK: begin
        if (!w_key_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (w_last) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
          w_press     = 1'b1;
        end else w_cnt_nxt = r_cnt + 1'b1;
      end
      HELD: begin
        if (!w_key_s) begin
          w_state_nxt = RELEASE_CHK;
          w_cnt_nxt   = '0;
        end
      end
      RELEASE_CHK: begin
        if (w_key_s) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (w_last) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else w_cnt_nxt = r_cnt + 1'b1;
      end
      default: begin
        w_state_nxt = LOCK;
        w_cnt_nxt   = '0;
      end
    endcase
  end
  // halt gates the divider combinationally so no auto step lands in a halted cycle
  assign w_manual = w_press & ~r_run_sync;
  assign w_div_en = r_running & ~halt;
  assign w_auto   = w_div_en & (r_div == DW'(RUN_DIV - 1));
  assign w_step   = w_manual | w_auto;
  always_ff @(posedge clock_reg or posedge reset) begin
    if (reset) begin
      r_key_meta <= 1'b1;
      r_key_sync <= 1'b1;
      r_run_meta <= 1'b0;
      r_run_sync <= 1'b0;
      r_state    <= LOCK;
      r_cnt      <= '0;
      r_div      <= '0;
      r_running  <= 1'b0;
      r_step_en  <= 1'b0;
      r_count    <= '0;
    end else begin
      r_key_meta <= key_n;
      r_key_sync <= r_key_meta;
      r_run_meta <= run_sw;
      r_run_sync <= r_run_meta;
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_div      <= (w_div_en & ~w_auto) ? r_div + 1'b1 : '0;
      r_running  <= r_run_sync & ~halt;
      r_step_en  <= w_step;
      r_count    <= r_count + COUNT_W'(w_step);
    end
  end
  assign step_en    = r_step_en;
  assign key_level  = (r_state == HELD) | (r_state == RELEASE_CHK);
  assign running    = r_running;
  assign step_count = r_count;
endmodule

// File: tb/tb_step_clock_ctrl.sv
// tb_step_clock_ctrl: scenario tasks with a cycle-stamped scoreboard of expected step pulses.
module tb_step_clock_ctrl;
  localparam int N = 4, RD = 8, CW = 4;
  logic clk = 1'b0, rst, key_n, run_sw, halt;
  logic step_en, key_level, running;
  logic [CW-1:0] step_count;
  int cyc = 0, n_chk = 0, n_pass = 0, exp_cnt = 0, mon_e;
  int q_exp[$];
  step_clock_ctrl #(.DEBOUNCE_CYCLES(N), .RUN_DIV(RD), .COUNT_W(CW)) dut (
    .clock_reg(clk), .reset(rst), .key_n(key_n), .run_sw(run_sw), .halt(halt),
    .step_en(step_en), .key_level(key_level), .running(running), .step_count(step_count));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (step_en === 1'b1) begin
      n_chk++;
      if (q_exp.size() == 0) $display("FAIL step_unexpected: step_en=1 at cycle %0d, required no step", cyc);
      else begin
        mon_e = q_exp.pop_front();
        if (cyc !== mon_e) $display("FAIL step_cycle: step_en at cycle %0d, required cycle %0d", cyc, mon_e);
        else n_pass++;
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1; key_n = 1'b1; run_sw = 1'b0; halt = 1'b0;
    tick(3);
    n_chk++; if (step_en !== 1'b0) $display("FAIL reset_step_en: got %b required 0", step_en); else n_pass++;
    n_chk++; if (key_level !== 1'b0) $display("FAIL reset_key_level: got %b required 0", key_level); else n_pass++;
    n_chk++; if (running !== 1'b0) $display("FAIL reset_running: got %b required 0", running); else n_pass++;
    n_chk++; if (step_count !== 4'd0) $display("FAIL reset_count: got %0d required 0", step_count); else n_pass++;
    rst = 1'b0; exp_cnt = 0;
    tick(8);
    n_chk++; if (key_level !== 1'b0) $display("FAIL post_reset_level: got %b required 0", key_level); else n_pass++;
  endtask
  task automatic test_clean_press();
    int c;
    c = cyc; key_n = 1'b0; q_exp.push_back(c + 7); exp_cnt++;
    tick(6);
    n_chk++; if (key_level !== 1'b0) $display("FAIL press_level_early: got %b required 0", key_level); else n_pass++;
    tick(1);
    n_chk++; if (key_level !== 1'b1) $display("FAIL press_level: got %b required 1", key_level); else n_pass++;
    n_chk++; if (step_count !== CW'(exp_cnt)) $display("FAIL press_count: got %0d required %0d", step_count, CW'(exp_cnt)); else n_pass++;
    tick(1);
    n_chk++; if (step_en !== 1'b0) $display("FAIL press_single: got %b required 0", step_en); else n_pass++;
    tick(12); key_n = 1'b1;
    tick(6);
    n_chk++; if (key_level !== 1'b1) $display("FAIL release_level_early: got %b required 1", key_level); else n_pass++;
    tick(1);
    n_chk++; if (key_level !== 1'b0) $display("FAIL release_level: got %b required 0", key_level); else n_pass++;
    tick(5);
    n_chk++; if (q_exp.size() != 0) $display("FAIL press_missing: %0d steps outstanding, required 0", q_exp.size()); else n_pass++;
  endtask
  task automatic test_bounce();
    int c, bad;
    c = cyc; key_n = 1'b0;
    tick(2); key_n = 1'b1;
    tick(1); key_n = 1'b0; q_exp.push_back(c + 10); exp_cnt++;
    tick(15); key_n = 1'b1;
    tick(10);
    n_chk++; if (step_count !== CW'(exp_cnt)) $display("FAIL bounce_count: got %0d required %0d", step_count, CW'(exp_cnt)); else n_pass++;
    bad = 0; key_n = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) key_n = 1'b1;
      tick(1);
      if (key_level !== 1'b0) bad++;
    end
    n_chk++; if (bad != 0) $display("FAIL glitch_level: key_level high %0d cycles, required 0", bad); else n_pass++;
    n_chk++; if (step_count !== CW'(exp_cnt)) $display("FAIL glitch_count: got %0d required %0d", step_count, CW'(exp_cnt)); else n_pass++;
    n_chk++; if (q_exp.size() != 0) $display("FAIL bounce_missing: %0d steps outstanding, required 0", q_exp.size()); else n_pass++;
  endtask
  task automatic test_reset_held();
    int c;
    c = cyc; key_n = 1'b0; q_exp.push_back(c + 7); exp_cnt++;
    tick(10);
    #2 rst = 1'b1;
    #1;
    n_chk++; if (step_count !== 4'd0) $display("FAIL midreset_count: got %0d required 0", step_count); else n_pass++;
    n_chk++; if (key_level !== 1'b0) $display("FAIL midreset_level: got %b required 0", key_level); else n_pass++;
    exp_cnt = 0;
    tick(2); rst = 1'b0;
    tick(20);
    n_chk++; if (key_level !== 1'b0) $display("FAIL lock_level: got %b required 0", key_level); else n_pass++;
    n_chk++; if (step_count !== 4'd0) $display("FAIL lock_count: got %0d required 0", step_count); else n_pass++;
    key_n = 1'b1;
    tick(6);
    c = cyc; key_n = 1'b0; q_exp.push_back(c + 7); exp_cnt++;
    tick(10);
    n_chk++; if (step_count !== CW'(exp_cnt)) $display("FAIL unlock_count: got %0d required %0d", step_count, CW'(exp_cnt)); else n_pass++;
    key_n = 1'b1;
    tick(10);
    n_chk++; if (q_exp.size() != 0) $display("FAIL unlock_missing: %0d steps outstanding, required 0", q_exp.size()); else n_pass++;
  endtask
  task automatic test_auto_run();
    int c;
    c = cyc; run_sw = 1'b1;
    for (int k = 11; k <= 43; k += RD) begin q_exp.push_back(c + k); exp_cnt++; end
    for (int i = 1; i <= 50; i++) begin
      tick(1);
      if (i == 4 || i == 30) key_n = 1'b0;
      if (i == 20 || i == 42) key_n = 1'b1;
      if (i == 15) begin
        n_chk++; if (key_level !== 1'b1) $display("FAIL auto_key_level: got %b required 1", key_level); else n_pass++;
      end
      if (i == 25) begin
        n_chk++; if (running !== 1'b1) $display("FAIL auto_running: got %b required 1", running); else n_pass++;
      end
    end
    halt = 1'b1;
    tick(1);
    n_chk++; if (running !== 1'b0) $display("FAIL halt_running: got %b required 0", running); else n_pass++;
    tick(4); halt = 1'b0;
    q_exp.push_back(c + 64); q_exp.push_back(c + 72); exp_cnt += 2;
    tick(2);
    n_chk++; if (running !== 1'b1) $display("FAIL resume_running: got %b required 1", running); else n_pass++;
    tick(18); run_sw = 1'b0;
    tick(10);
    n_chk++; if (running !== 1'b0) $display("FAIL stop_running: got %b required 0", running); else n_pass++;
    n_chk++; if (step_count !== CW'(exp_cnt)) $display("FAIL auto_count: got %0d required %0d", step_count, CW'(exp_cnt)); else n_pass++;
    n_chk++; if (q_exp.size() != 0) $display("FAIL auto_missing: %0d steps outstanding, required 0", q_exp.size()); else n_pass++;
  endtask
  task automatic test_wrap();
    int c;
    rst = 1'b1;
    tick(1); rst = 1'b0; exp_cnt = 0;
    tick(8);
    for (int p = 0; p < 16; p++) begin
      c = cyc; key_n = 1'b0; q_exp.push_back(c + 7); exp_cnt++;
      tick(10);
      n_chk++; if (step_count !== CW'(exp_cnt)) $display("FAIL wrap_count_%0d: got %0d required %0d", p, step_count, CW'(exp_cnt)); else n_pass++;
      key_n = 1'b1;
      tick(10);
    end
    n_chk++; if (step_count !== 4'd0) $display("FAIL wrap_zero: got %0d required 0", step_count); else n_pass++;
    n_chk++; if (q_exp.size() != 0) $display("FAIL wrap_missing: %0d steps outstanding, required 0", q_exp.size()); else n_pass++;
  endtask
  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_reset_held();
    test_auto_run();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
